// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and config-link register map for the boot-time tile configuration loader.
package bp_cfg_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FREEZE,
      S_CORE_ID,
      S_MODE_UC,
      S_UC_RD,
      S_UC_WR,
      S_MODE_NORM,
      S_UNFREEZE,
      S_DRAIN,
      S_DONE
   } bp_cfg_loader_state_e;

   typedef enum logic [0:0] {
      CCE_MODE_UNCACHED = 1'b0,
      CCE_MODE_NORMAL   = 1'b1
   } bp_cce_mode_e;

   localparam logic [15:0] CFG_ADDR_FREEZE     = 16'h0001;
   localparam logic [15:0] CFG_ADDR_CORE_ID    = 16'h0002;
   localparam logic [15:0] CFG_ADDR_CCE_MODE   = 16'h0003;
   localparam logic [15:0] CFG_ADDR_UCODE_BASE = 16'h8000;

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Outstanding posted-write tracker: +1 per issued command, -1 per ack, net zero when both
// land in the same cycle. An ack with nothing outstanding is dropped.
module bp_cfg_credit_counter #(
   parameter int credits_p = 8
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic empty_o
);

   localparam int cnt_width_lp = $clog2(credits_p + 1);

   logic [cnt_width_lp-1:0] count_q, count_d;
   logic                    dec_eff;

   assign dec_eff = dec_i && (count_q != '0);
   assign full_o  = (count_q == cnt_width_lp'(credits_p));
   assign empty_o = (count_q == '0);

   always_comb begin
      count_d = count_q;
      unique case ({inc_i, dec_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) count_q <= '0;
      else            count_q <= count_d;
   end

   // A stray ack points at a broken network or a lost reset; it must never happen.
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(dec_i && empty_o));
      end
   end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot sequencer: freezes each core, writes ID/mode, streams CCE microcode, unfreezes, then
// drains acks. Optional ack watchdog enabled by defining BP_CFG_LOADER_TIMEOUT_EN.
module bp_cfg_loader
   import bp_cfg_loader_pkg::*;
#(
   parameter int num_core_p       = 1,
   parameter int core_id_width_p  = 6,
   parameter int cfg_addr_width_p = 16,
   parameter int cfg_data_width_p = 64,
   parameter int ucode_els_p      = 256,
   parameter int credits_p        = 8,
   parameter int timeout_p        = 1024,
   localparam int uc_width_lp     = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        start_i,
   output logic                        cfg_cmd_v_o,
   input  logic                        cfg_cmd_ready_i,
   output logic [core_id_width_p-1:0]  cfg_cmd_dst_o,
   output logic [cfg_addr_width_p-1:0] cfg_cmd_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_cmd_data_o,
   input  logic                        cfg_resp_v_i,
   output logic                        cfg_resp_yumi_o,
   output logic                        ucode_r_v_o,
   output logic [uc_width_lp-1:0]      ucode_addr_o,
   input  logic [cfg_data_width_p-1:0] ucode_data_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o
);

   bp_cfg_loader_state_e         state_q, state_d;
   logic [core_id_width_p-1:0]   core_q, core_d;
   logic [uc_width_lp-1:0]       uc_q, uc_d;
   logic [cfg_data_width_p-1:0]  uc_data_q, uc_data_d;
   logic                         uc_fresh_q, uc_fresh_d;
   logic                         cmd_wr, cmd_xfer, credit_full, credit_empty;
   logic                         timeout_hit;

   assign cmd_xfer        = cfg_cmd_v_o && cfg_cmd_ready_i;
   assign cfg_cmd_v_o     = cmd_wr && !credit_full;
   assign cfg_cmd_dst_o   = cmd_wr ? core_q : '0;
   assign cfg_resp_yumi_o = cfg_resp_v_i;
   assign ucode_addr_o    = uc_q;
   assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o          = (state_q == S_DONE);

   bp_cfg_credit_counter #(.credits_p(credits_p)) credits (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (cmd_xfer),
      .dec_i     (cfg_resp_v_i),
      .full_o    (credit_full),
      .empty_o   (credit_empty)
   );

   always_comb begin
      state_d        = state_q;
      core_d         = core_q;
      uc_d           = uc_q;
      uc_data_d      = uc_data_q;
      uc_fresh_d     = 1'b0;
      cmd_wr         = 1'b0;
      cfg_cmd_addr_o = '0;
      cfg_cmd_data_o = '0;
      ucode_r_v_o    = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_FREEZE;
               core_d  = '0;
               uc_d    = '0;
            end
         end
         S_FREEZE: begin
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_FREEZE);
            cfg_cmd_data_o = cfg_data_width_p'(1);
            if (cmd_xfer) state_d = S_CORE_ID;
         end
         S_CORE_ID: begin
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_CORE_ID);
            cfg_cmd_data_o = cfg_data_width_p'(core_q);
            if (cmd_xfer) state_d = S_MODE_UC;
         end
         S_MODE_UC: begin
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_CCE_MODE);
            cfg_cmd_data_o = cfg_data_width_p'(CCE_MODE_UNCACHED);
            if (cmd_xfer) state_d = S_UC_RD;
         end
         S_UC_RD: begin
            ucode_r_v_o = 1'b1;
            uc_fresh_d  = 1'b1;
            state_d     = S_UC_WR;
         end
         S_UC_WR: begin
            // ROM word is live on the first UC_WR cycle only; afterwards the captured copy is shown.
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_UCODE_BASE) + cfg_addr_width_p'(uc_q);
            cfg_cmd_data_o = uc_fresh_q ? ucode_data_i : uc_data_q;
            if (uc_fresh_q) uc_data_d = ucode_data_i;
            if (cmd_xfer) begin
               if (uc_q == uc_width_lp'(ucode_els_p - 1)) begin
                  uc_d    = '0;
                  state_d = S_MODE_NORM;
               end else begin
                  uc_d    = uc_q + 1'b1;
                  state_d = S_UC_RD;
               end
            end
         end
         S_MODE_NORM: begin
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_CCE_MODE);
            cfg_cmd_data_o = cfg_data_width_p'(CCE_MODE_NORMAL);
            if (cmd_xfer) state_d = S_UNFREEZE;
         end
         S_UNFREEZE: begin
            cmd_wr         = 1'b1;
            cfg_cmd_addr_o = cfg_addr_width_p'(CFG_ADDR_FREEZE);
            cfg_cmd_data_o = '0;
            if (cmd_xfer) begin
               if (core_q == core_id_width_p'(num_core_p - 1)) begin
                  state_d = S_DRAIN;
               end else begin
                  core_d  = core_q + 1'b1;
                  uc_d    = '0;
                  state_d = S_FREEZE;
               end
            end
         end
         S_DRAIN: begin
            if (credit_empty) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (timeout_hit && busy_o) state_d = S_DONE;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         core_q     <= '0;
         uc_q       <= '0;
         uc_data_q  <= '0;
         uc_fresh_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         core_q     <= core_d;
         uc_q       <= uc_d;
         uc_data_q  <= uc_data_d;
         uc_fresh_q <= uc_fresh_d;
      end
   end

`ifdef BP_CFG_LOADER_TIMEOUT_EN
   localparam int timer_width_lp = $clog2(timeout_p + 1);

   logic [timer_width_lp-1:0] timer_q, timer_d;
   logic                      error_q, error_d, timer_run;

   // Watchdog counts cycles with writes in flight and no ack; every ack restarts it.
   always_comb begin
      timer_run   = !credit_empty && !cfg_resp_v_i;
      timeout_hit = timer_run && (timer_q == timer_width_lp'(timeout_p - 1));
      timer_d     = '0;
      if (timer_run) timer_d = timeout_hit ? timer_q : timer_q + 1'b1;
      error_d = error_q;
      if (start_i && !busy_o)     error_d = 1'b0;
      if (timeout_hit && busy_o)  error_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         timer_q <= '0;
         error_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         error_q <= error_d;
      end
   end

   assign error_o = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: 2 cores, 4 ucode words, 2 credits, ROM model and ack model.
module tb_bp_cfg_loader;

   localparam int NC    = 2;
   localparam int UE    = 4;
   localparam int CR    = 2;
   localparam int TO    = 16;
   localparam int WPC   = UE + 5;
   localparam int TOTAL = NC * WPC;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic        cfg_cmd_ready_i = 1'b0;
   logic        cfg_cmd_v_o;
   logic [5:0]  cfg_cmd_dst_o;
   logic [15:0] cfg_cmd_addr_o;
   logic [63:0] cfg_cmd_data_o;
   logic        cfg_resp_v_i;
   logic        cfg_resp_yumi_o;
   logic        ucode_r_v_o;
   logic [1:0]  ucode_addr_o;
   logic [63:0] ucode_data_i;
   logic        busy_o, done_o, error_o;

   always #5 clk_i = ~clk_i;

   bp_cfg_loader #(
      .num_core_p(NC), .core_id_width_p(6), .cfg_addr_width_p(16), .cfg_data_width_p(64),
      .ucode_els_p(UE), .credits_p(CR), .timeout_p(TO)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
      .cfg_cmd_v_o(cfg_cmd_v_o), .cfg_cmd_ready_i(cfg_cmd_ready_i),
      .cfg_cmd_dst_o(cfg_cmd_dst_o), .cfg_cmd_addr_o(cfg_cmd_addr_o),
      .cfg_cmd_data_o(cfg_cmd_data_o), .cfg_resp_v_i(cfg_resp_v_i),
      .cfg_resp_yumi_o(cfg_resp_yumi_o), .ucode_r_v_o(ucode_r_v_o),
      .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rom_val(input int i);
      return 64'hC0DE_0000_0000_0ABC + 64'(i) * 64'h0000_0001_1111_1111;
   endfunction

   // Synchronous ROM; output turns to junk when not read so a re-read-free loader must hold its copy.
   always @(posedge clk_i) ucode_data_i <= ucode_r_v_o ? rom_val(int'(ucode_addr_o)) : {$urandom, $urandom};

   logic [5:0]  log_dst  [64];
   logic [15:0] log_addr [64];
   logic [63:0] log_data [64];
   int   nlog = 0, nreads = 0, owed = 0, acks_given = 0, ack_limit = 1000000;
   int   ack_mode = 0;     // 0 none, 1 two-cycle delay, 2 ack whenever owed, 3 manual
   logic man_req = 1'b0, p0 = 1'b0, p1 = 1'b0, resp_r = 1'b0, xfer;
   logic stall_prev = 1'b0;
   logic [85:0] prev_cmd;

   assign cfg_resp_v_i = resp_r & reset_n_i;

   // Monitor and ack model, sampled between edges; decisions apply to the following posedge.
   always @(negedge clk_i) begin
      #2;
      if (!reset_n_i) begin
         owed = 0; p0 = 1'b0; p1 = 1'b0; resp_r = 1'b0; stall_prev = 1'b0;
      end else begin
         case (ack_mode)
            1:       resp_r = p1;
            2:       resp_r = (owed > 0);
            3:       resp_r = man_req;
            default: resp_r = 1'b0;
         endcase
         if (acks_given >= ack_limit) resp_r = 1'b0;
         if (resp_r) acks_given++;
         if (owed == CR) chk("credit_cap_v", cfg_cmd_v_o, 1'b0);
         if (stall_prev)
            chk("hold_stable", {cfg_cmd_v_o, cfg_cmd_dst_o, cfg_cmd_addr_o, cfg_cmd_data_o},
                {1'b1, prev_cmd});
         stall_prev = cfg_cmd_v_o && !cfg_cmd_ready_i;
         prev_cmd   = {cfg_cmd_dst_o, cfg_cmd_addr_o, cfg_cmd_data_o};
         xfer = cfg_cmd_v_o && cfg_cmd_ready_i;
         if (xfer && nlog < 64) begin
            log_dst[nlog]  = cfg_cmd_dst_o;
            log_addr[nlog] = cfg_cmd_addr_o;
            log_data[nlog] = cfg_cmd_data_o;
            $display("write %0d: dst=%0d addr=%h data=%h", nlog, cfg_cmd_dst_o, cfg_cmd_addr_o, cfg_cmd_data_o);
            nlog++;
         end
         if (ucode_r_v_o) nreads++;
         owed = owed + int'(xfer) - int'(resp_r);
         p1 = p0;
         p0 = xfer;
      end
   end

   task automatic pulse_start();
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      #3;
      while (!done_o && c < budget) begin
         @(negedge clk_i); #3; c++;
      end
      chk("done_reached", done_o, 1'b1);
   endtask

   task automatic wait_log(input int n, input int budget);
      int c;
      c = 0;
      while (nlog < n && c < budget) begin
         @(negedge clk_i); #3; c++;
      end
      chk("log_reached", nlog, n);
   endtask

   task automatic check_seq();
      chk("write_count", nlog, TOTAL);
      chk("rom_reads", nreads, NC * UE);
      for (int k = 0; k < TOTAL && k < nlog; k++) begin
         int          c, j;
         logic [15:0] a;
         logic [63:0] d;
         c = k / WPC;
         j = k % WPC;
         if (j == 0)           begin a = 16'h0001; d = 64'd1; end
         else if (j == 1)      begin a = 16'h0002; d = 64'(c); end
         else if (j == 2)      begin a = 16'h0003; d = 64'd0; end
         else if (j < UE + 3)  begin a = 16'h8000 + 16'(j - 3); d = rom_val(j - 3); end
         else if (j == UE + 3) begin a = 16'h0003; d = 64'd1; end
         else                  begin a = 16'h0001; d = 64'd0; end
         chk($sformatf("write%0d", k), {log_dst[k], log_addr[k], log_data[k]}, {6'(c), a, d});
      end
   endtask

   initial begin
      int c;
      // Reset state
      repeat (3) @(negedge clk_i);
      #3;
      chk("reset_outs", {cfg_cmd_v_o, busy_o, done_o, error_o, ucode_r_v_o, cfg_resp_yumi_o},
          6'b0);
      chk("reset_cmd", {cfg_cmd_dst_o, cfg_cmd_addr_o, cfg_cmd_data_o, ucode_addr_o}, 88'b0);
      @(negedge clk_i); reset_n_i = 1'b1;

      // Full sequence, always ready, acks two cycles later; a stray start mid-run is ignored
      ack_mode = 1; cfg_cmd_ready_i = 1'b1; nlog = 0; nreads = 0;
      pulse_start();
      #3 chk("busy_after_start", busy_o, 1'b1);
      repeat (6) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
      wait_done(400);
      check_seq();
      chk("done_state", {busy_o, done_o, error_o}, 3'b010);

      // Random backpressure
      nlog = 0; nreads = 0;
      pulse_start();
      #3 chk("done_cleared", done_o, 1'b0);
      c = 0;
      while (!done_o && c < 2000) begin
         @(negedge clk_i); cfg_cmd_ready_i = 1'($urandom_range(0, 1));
         #3; c++;
      end
      cfg_cmd_ready_i = 1'b1;
      chk("done_backpressure", done_o, 1'b1);
      check_seq();

      // Credit limit with acks withheld, then ack and transfer in the same cycle
      ack_mode = 3; man_req = 1'b0; nlog = 0; nreads = 0;
      pulse_start();
      repeat (12) @(negedge clk_i);
      #3;
      chk("credit_writes", nlog, CR);
      chk("credit_v_low", cfg_cmd_v_o, 1'b0);
      @(negedge clk_i); man_req = 1'b1;
      #3 chk("yumi_follows", cfg_resp_yumi_o, 1'b1);
      @(negedge clk_i); man_req = 1'b1;
      @(negedge clk_i); man_req = 1'b0;
      repeat (5) @(negedge clk_i);
      #3;
      chk("credit_resume", nlog, 4);
      chk("credit_v_low2", cfg_cmd_v_o, 1'b0);
      ack_mode = 2;
      wait_done(600);
      check_seq();

      // Asynchronous reset during core 1 microcode, then restart from core 0
      ack_mode = 1; nlog = 0; nreads = 0;
      pulse_start();
      wait_log(WPC + 4, 400);
      @(negedge clk_i); #4 reset_n_i = 1'b0;
      #1;
      chk("async_reset_outs", {cfg_cmd_v_o, busy_o, done_o, error_o, ucode_r_v_o, cfg_resp_yumi_o},
          6'b0);
      chk("async_reset_cmd", {cfg_cmd_dst_o, cfg_cmd_addr_o, cfg_cmd_data_o, ucode_addr_o}, 88'b0);
      repeat (3) @(negedge clk_i);
      reset_n_i = 1'b1;
      nlog = 0; nreads = 0;
      pulse_start();
      wait_done(400);
      check_seq();

      // Last ack dropped
      ack_limit = acks_given + TOTAL - 1; nlog = 0; nreads = 0;
      pulse_start();
      wait_log(TOTAL, 400);
`ifdef BP_CFG_LOADER_TIMEOUT_EN
      wait_done(100);
      chk("timeout_flags", {busy_o, done_o, error_o}, 3'b011);
`else
      repeat (40) @(negedge clk_i);
      #3;
      chk("drain_stuck", {busy_o, done_o, error_o}, 3'b100);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
